// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: both requester ports plus the 16-bit
// system memory port. The arbiter takes the slave view; whatever drives the
// requests and models the memory takes the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    // core requester
    logic          C_Req;
    logic [3:0]    C_Len;
    logic          C_RD;
    logic          C_WR;
    logic [AW-1:0] C_Addr;
    logic [DW-1:0] C_WData;
    logic          C_Gnt;
    logic          C_RValid;
    logic [DW-1:0] C_RData;
    logic          C_Done;
    // DMA requester
    logic          D_Req;
    logic [3:0]    D_Len;
    logic          D_RD;
    logic          D_WR;
    logic [AW-1:0] D_Addr;
    logic [DW-1:0] D_WData;
    logic          D_Gnt;
    logic          D_RValid;
    logic [DW-1:0] D_RData;
    logic          D_Done;
    // memory port and status
    logic          To_Err;
    logic [AW-1:0] Addr;
    logic          RD;
    logic          WR;
    logic [DW-1:0] DataOut;
    logic [DW-1:0] DataIn;

    modport slave (
        input  C_Req, C_Len, C_RD, C_WR, C_Addr, C_WData,
        input  D_Req, D_Len, D_RD, D_WR, D_Addr, D_WData,
        input  DataIn,
        output C_Gnt, C_RValid, C_RData, C_Done,
        output D_Gnt, D_RValid, D_RData, D_Done,
        output To_Err, Addr, RD, WR, DataOut
    );

    modport master (
        output C_Req, C_Len, C_RD, C_WR, C_Addr, C_WData,
        output D_Req, D_Len, D_RD, D_WR, D_Addr, D_WData,
        output DataIn,
        input  C_Gnt, C_RValid, C_RData, C_Done,
        input  D_Gnt, D_RValid, D_RData, D_Done,
        input  To_Err, Addr, RD, WR, DataOut
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin burst arbiter between the CVP14 core and the
// DMA loader for the shared 16-bit memory port. Whole bursts (1..16 beats)
// are granted; each accepted beat is registered onto Addr/RD/WR/DataOut and
// read data comes back to the beat's owner two cycles after the beat.
// Optional grant watchdog: define ARB_TIMEOUT_EN to revoke a grant after
// TIMEOUT consecutive idle cycles (pulses To_Err with Done).
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 32
) (
    input logic              Clk1,
    input logic              Reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_C = 2'd1,
        GNT_D = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic          owner_reg;       // 0 = core, 1 = DMA; doubles as last_owner
    logic [3:0]    len_reg;
    logic [3:0]    cnt_reg;
    logic [AW-1:0] addr_reg;
    logic          rd_reg;
    logic          wr_reg;
    logic [DW-1:0] dout_reg;
    logic          beat_owner_reg;  // owner of the access currently on the port
    logic          c_rvalid_reg;
    logic          d_rvalid_reg;

    logic          sel_req;
    logic          sel_rd;
    logic          sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          in_gnt;
    logic          beat;
    logic          last_beat;
    logic          grant_c;
    logic          grant_d;
    logic          timeout_hit;

    // Steer the current owner's request signals; the other side is ignored.
    always_comb begin
        sel_req   = bus.C_Req;
        sel_rd    = bus.C_RD;
        sel_wr    = bus.C_WR;
        sel_addr  = bus.C_Addr;
        sel_wdata = bus.C_WData;
        if (owner_reg) begin
            sel_req   = bus.D_Req;
            sel_rd    = bus.D_RD;
            sel_wr    = bus.D_WR;
            sel_addr  = bus.D_Addr;
            sel_wdata = bus.D_WData;
        end
    end

    assign in_gnt    = (state_reg == GNT_C) || (state_reg == GNT_D);
    // A Req drop wins over a strobe in the same cycle: no beat is taken.
    assign beat      = in_gnt && sel_req && (sel_rd || sel_wr);
    assign last_beat = beat && (cnt_reg == len_reg);

`ifdef ARB_TIMEOUT_EN
    logic [31:0] idle_reg;
    logic        to_err_reg;

    assign timeout_hit = in_gnt && sel_req && !beat && (idle_reg == 32'(TIMEOUT - 1));

    // Count consecutive idle cycles of a grant; flag a revoke for the DRAIN cycle.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            idle_reg   <= 32'd0;
            to_err_reg <= 1'b0;
        end else begin
            to_err_reg <= timeout_hit;
            if (!in_gnt || beat) begin
                idle_reg <= 32'd0;
            end else begin
                idle_reg <= idle_reg + 32'd1;
            end
        end
    end

    assign bus.To_Err = to_err_reg;
`else
    // Without the watchdog a grant lasts until its last beat or a Req drop.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign bus.To_Err     = 1'b0;
`endif

    // Next-state: round-robin on ties (the requester that was not last owner wins).
    always_comb begin
        state_next = state_reg;
        grant_c    = 1'b0;
        grant_d    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.C_Req && (!bus.D_Req || owner_reg)) begin
                    state_next = GNT_C;
                    grant_c    = 1'b1;
                end else if (bus.D_Req) begin
                    state_next = GNT_D;
                    grant_d    = 1'b1;
                end
            end
            GNT_C, GNT_D: begin
                if (!sel_req || last_beat || timeout_hit) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, owner, burst length and beat counter.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            state_reg <= IDLE;
            owner_reg <= 1'b1;
            len_reg   <= 4'd0;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            if (grant_c || grant_d) begin
                owner_reg <= grant_d;
                len_reg   <= grant_d ? bus.D_Len : bus.C_Len;
                cnt_reg   <= 4'd0;
            end else if (beat) begin
                cnt_reg <= cnt_reg + 4'd1;
            end
        end
    end

    // Register each beat onto the memory port; address and data hold between beats.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            addr_reg       <= '0;
            rd_reg         <= 1'b0;
            wr_reg         <= 1'b0;
            dout_reg       <= '0;
            beat_owner_reg <= 1'b0;
        end else begin
            rd_reg <= beat && sel_rd && !sel_wr;
            wr_reg <= beat && sel_wr;
            if (beat) begin
                addr_reg       <= sel_addr;
                dout_reg       <= sel_wdata;
                beat_owner_reg <= owner_reg;
            end
        end
    end

    // Read data is valid the cycle after RD; route the valid to that beat's owner.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            c_rvalid_reg <= 1'b0;
            d_rvalid_reg <= 1'b0;
        end else begin
            c_rvalid_reg <= rd_reg && !beat_owner_reg;
            d_rvalid_reg <= rd_reg && beat_owner_reg;
        end
    end

    assign bus.C_Gnt    = (state_reg == GNT_C);
    assign bus.D_Gnt    = (state_reg == GNT_D);
    assign bus.C_Done   = (state_reg == DRAIN) && !owner_reg;
    assign bus.D_Done   = (state_reg == DRAIN) && owner_reg;
    assign bus.C_RValid = c_rvalid_reg;
    assign bus.D_RValid = d_rvalid_reg;
    assign bus.C_RData  = bus.DataIn;
    assign bus.D_RData  = bus.DataIn;
    assign bus.Addr     = addr_reg;
    assign bus.RD       = rd_reg;
    assign bus.WR       = wr_reg;
    assign bus.DataOut  = dout_reg;
endmodule
